score_bcd_display: RTL and testbench

//  Parametrised score/length display driver for the snake game. Accepts a binary value over a

---
 rtl/snake_disp_pkg.sv | 34 +++
 rtl/score_bcd_display_bcd_to_seg7.sv | 15 +
 rtl/score_bcd_display.sv | 157 +++++++++++++++
 tb/tb_score_bcd_display.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_disp_pkg.sv
// Shared constants for the snake game score display: FSM encodings,
// 7-segment code table (active-low {g,f,e,d,c,b,a}) and a power-of-ten helper.
package snake_disp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t LATCH = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/score_bcd_display_bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment pattern; codes 10-15 show blank.
module bcd_to_seg7
  import snake_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // NOTE: assign a default before any conditional write so no latch is inferred.
  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/score_bcd_display.sv
// Binary-to-BCD score display driver (shift-add-3, one bit per clock) with
// registered BCD and 7-segment outputs. Optional macro SNAKE_SEG_LZ_BLANK_EN blanks leading zeros.
module score_bcd_display
  import snake_disp_pkg::*;
#(
  parameter int VAL_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VAL_W-1:0]      in_value,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   seg_out,
  output logic                  done,
  output logic                  overflow
);

`ifdef SNAKE_SEG_LZ_BLANK_EN
  localparam bit LZ_BLANK = 1'b1;
`else
  localparam bit LZ_BLANK = 1'b0;
`endif

  localparam int SW = 4*DIGITS + VAL_W;
  localparam int CW = $clog2(VAL_W + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(VAL_W);

  function automatic logic [7*DIGITS-1:0] seg_reset_value();
    logic [7*DIGITS-1:0] v;
    for (int k = 0; k < DIGITS; k++)
      v[7*k +: 7] = (k == 0 || !LZ_BLANK) ? SEG_ZERO : SEG_BLANK;
    return v;
  endfunction

  localparam logic [7*DIGITS-1:0] SEG_RST = seg_reset_value();

  state_t                state_q, state_d;
  logic [SW-1:0]         scratch_q, scratch_d, adj;
  logic [CW-1:0]         count_q, count_d;
  logic                  sat_q, sat_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [7*DIGITS-1:0]   seg_q, seg_d;
  logic                  overflow_q, overflow_d;
  logic                  done_q, done_d;
  logic                  in_ready_q, in_ready_d;

  logic [VAL_W-1:0]      in_value_sat;
  logic                  in_sat;
  logic [4*DIGITS-1:0]   bcd_final;
  logic [7*DIGITS-1:0]   seg_raw, seg_disp;
  logic                  lead_zero;

  // Saturation logic exists only when the input range can exceed the display range.
  generate
    if ((longint'(1) << VAL_W) > pow10(DIGITS)) begin : g_sat
      localparam logic [VAL_W-1:0] SAT_VAL = VAL_W'(pow10(DIGITS) - 1);
      assign in_sat       = (in_value > SAT_VAL);
      assign in_value_sat = in_sat ? SAT_VAL : in_value;
    end else begin : g_nosat
      assign in_sat       = 1'b0;
      assign in_value_sat = in_value;
    end
  endgenerate

  assign bcd_final = scratch_q[SW-1 -: 4*DIGITS];

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bcd_to_seg7 u_seg (
        .bcd (bcd_final[4*k +: 4]),
        .seg (seg_raw[7*k +: 7])
      );
    end
  endgenerate

  // Scan from the most significant digit; the units digit is never blanked.
  always_comb begin
    seg_disp  = seg_raw;
    lead_zero = LZ_BLANK;
    for (int k = DIGITS-1; k >= 1; k--) begin
      if (lead_zero && bcd_final[4*k +: 4] == 4'd0) seg_disp[7*k +: 7] = SEG_BLANK;
      else                                          lead_zero = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    scratch_d  = scratch_q;
    count_d    = count_q;
    sat_d      = sat_q;
    bcd_d      = bcd_q;
    seg_d      = seg_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    adj        = scratch_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          scratch_d = {{(4*DIGITS){1'b0}}, in_value_sat};
          count_d   = COUNT_INIT;
          sat_d     = in_sat;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        for (int k = 0; k < DIGITS; k++)
          if (adj[VAL_W + 4*k +: 4] >= 4'd5) adj[VAL_W + 4*k +: 4] = adj[VAL_W + 4*k +: 4] + 4'd3;
        scratch_d = {adj[SW-2:0], 1'b0};
        count_d   = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = LATCH;
      end
      LATCH: begin
        bcd_d      = bcd_final;
        seg_d      = seg_disp;
        overflow_d = sat_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      scratch_q  <= '0;
      count_q    <= '0;
      sat_q      <= 1'b0;
      bcd_q      <= '0;
      seg_q      <= SEG_RST;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      scratch_q  <= scratch_d;
      count_q    <= count_d;
      sat_q      <= sat_d;
      bcd_q      <= bcd_d;
      seg_q      <= seg_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign bcd_out  = bcd_q;
  assign seg_out  = seg_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed self-checking bench for score_bcd_display (default and 14-bit/4-digit instances).
module tb_score_bcd_display;

`ifdef SNAKE_SEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  in_value = '0;
  logic [11:0] bcd_out;
  logic [20:0] seg_out;
  logic        done, overflow;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [13:0] in_value2 = '0;
  logic [15:0] bcd_out2;
  logic [27:0] seg_out2;
  logic        done2, overflow2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  score_bcd_display #(.VAL_W(10), .DIGITS(3)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .bcd_out(bcd_out), .seg_out(seg_out), .done(done), .overflow(overflow)
  );

  score_bcd_display #(.VAL_W(14), .DIGITS(4)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_value(in_value2), .bcd_out(bcd_out2), .seg_out(seg_out2), .done(done2), .overflow(overflow2)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [9:0] v, output int lat);
    int guard;
    guard = 0;
    in_value = v;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin tick(); lat++; end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout value=%0d: no done within 40 edges", v);
    end
  endtask

  task automatic send2(input logic [13:0] v, output int lat);
    int guard;
    guard = 0;
    in_value2 = v;
    in_valid2 = 1'b1;
    while (!in_ready2 && guard < 50) begin tick(); guard++; end
    tick();
    in_valid2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 40) begin tick(); lat++; end
    n_checks++;
    if (done2 !== 1'b1) begin
      n_fail++;
      $display("FAIL send2_timeout value=%0d: no done within 40 edges", v);
    end
  endtask

  task automatic test_reset();
    logic [20:0] exp_seg;
    exp_seg = LZ ? {SB, SB, S0} : {S0, S0, S0};
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    n_checks++;
    if (bcd_out !== 12'h000) begin n_fail++; $display("FAIL reset_bcd got=%h exp=000", bcd_out); end
    n_checks++;
    if (seg_out !== exp_seg) begin n_fail++; $display("FAIL reset_seg got=%b exp=%b", seg_out, exp_seg); end
    n_checks++;
    if (done !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags done=%b overflow=%b exp 0,0", done, overflow);
    end
    n_checks++;
    if (in_ready !== 1'b1 || in_ready2 !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got=%b/%b exp 1/1", in_ready, in_ready2);
    end
  endtask

  task automatic test_basic();
    int lat;
    send(10'd200, lat);
    n_checks++;
    if (lat !== 11) begin n_fail++; $display("FAIL basic_latency got=%0d exp=11", lat); end
    n_checks++;
    if (bcd_out !== 12'h200) begin n_fail++; $display("FAIL basic_bcd got=%h exp=200", bcd_out); end
    n_checks++;
    if (seg_out !== {S2, S0, S0}) begin n_fail++; $display("FAIL basic_seg got=%b exp=%b", seg_out, {S2, S0, S0}); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got=%b exp=0", overflow); end
    tick();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_saturation();
    int lat;
    logic [9:0]  vals [4];
    logic [11:0] exp_bcd [4];
    logic        exp_ovf [4];
    vals[0] = 10'd1023; exp_bcd[0] = 12'h999; exp_ovf[0] = 1'b1;
    vals[1] = 10'd137;  exp_bcd[1] = 12'h137; exp_ovf[1] = 1'b0;
    vals[2] = 10'd999;  exp_bcd[2] = 12'h999; exp_ovf[2] = 1'b0;
    vals[3] = 10'd1000; exp_bcd[3] = 12'h999; exp_ovf[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(vals[i], lat);
      n_checks++;
      if (bcd_out !== exp_bcd[i] || overflow !== exp_ovf[i]) begin
        n_fail++;
        $display("FAIL sat_%0d value=%0d got bcd=%h ovf=%b exp bcd=%h ovf=%b",
                 i, vals[i], bcd_out, overflow, exp_bcd[i], exp_ovf[i]);
      end
    end
    n_checks++;
    if (seg_out !== {S9, S9, S9}) begin n_fail++; $display("FAIL sat_seg got=%b exp=%b", seg_out, {S9, S9, S9}); end
  endtask

  task automatic test_reset_mid();
    int  lat, guard;
    bit  saw_done;
    logic [20:0] exp_seg;
    exp_seg = LZ ? {SB, SB, S0} : {S0, S0, S0};
    saw_done = 1'b0;
    guard = 0;
    in_value = 10'd555;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    tick();
    in_valid = 1'b0;
    repeat (5) begin tick(); if (done) saw_done = 1'b1; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (done) saw_done = 1'b1;
    n_checks++;
    if (bcd_out !== 12'h000 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL midreset_out bcd=%h ovf=%b exp 000,0", bcd_out, overflow);
    end
    n_checks++;
    if (seg_out !== exp_seg) begin n_fail++; $display("FAIL midreset_seg got=%b exp=%b", seg_out, exp_seg); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got=%b exp=1", in_ready); end
    repeat (15) begin tick(); if (done) saw_done = 1'b1; end
    n_checks++;
    if (saw_done) begin n_fail++; $display("FAIL midreset_no_done got done=1 exp none"); end
    send(10'd42, lat);
    n_checks++;
    if (bcd_out !== 12'h042 || lat !== 11) begin
      n_fail++; $display("FAIL midreset_next bcd=%h lat=%0d exp 042,11", bcd_out, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  vals [3];
    int          done_cyc [3];
    logic [11:0] got [3];
    int          idx, ndone;
    logic        acc;
    logic [11:0] hold;
    bit          unstable;
    vals[0] = 10'd1; vals[1] = 10'd2; vals[2] = 10'd3;
    idx = 0; ndone = 0; unstable = 1'b0; hold = bcd_out;
    in_value = vals[0];
    in_valid = 1'b1;
    for (int cyc = 1; cyc <= 80 && ndone < 3; cyc++) begin
      acc = in_ready && in_valid;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) in_value = vals[idx];
        else         in_valid = 1'b0;
      end
      if (done) begin
        got[ndone] = bcd_out; done_cyc[ndone] = cyc; ndone++; hold = bcd_out;
      end else if (bcd_out !== hold) unstable = 1'b1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (ndone !== 3) begin n_fail++; $display("FAIL b2b_count got=%0d exp=3", ndone); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got[i] !== 12'(i + 1)) begin n_fail++; $display("FAIL b2b_value_%0d got=%h exp=%h", i, got[i], 12'(i + 1)); end
    end
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (done_cyc[i] - done_cyc[i-1] !== 12) begin
        n_fail++; $display("FAIL b2b_spacing_%0d got=%0d exp=12", i, done_cyc[i] - done_cyc[i-1]);
      end
    end
    n_checks++;
    if (unstable) begin n_fail++; $display("FAIL b2b_stable outputs changed between done pulses"); end
  endtask

  task automatic test_resubmit();
    int lat;
    send(10'd3, lat);
    n_checks++;
    if (bcd_out !== 12'h003 || lat !== 11) begin
      n_fail++; $display("FAIL resubmit bcd=%h lat=%0d exp 003,11", bcd_out, lat);
    end
  endtask

  task automatic test_blanking();
    int lat;
    logic [20:0] exp_seg;
    send(10'd7, lat);
    exp_seg = LZ ? {SB, SB, S7} : {S0, S0, S7};
    n_checks++;
    if (seg_out !== exp_seg) begin n_fail++; $display("FAIL blank_7 got=%b exp=%b", seg_out, exp_seg); end
    send(10'd0, lat);
    exp_seg = LZ ? {SB, SB, S0} : {S0, S0, S0};
    n_checks++;
    if (seg_out !== exp_seg || bcd_out !== 12'h000) begin
      n_fail++; $display("FAIL blank_0 seg=%b bcd=%h exp seg=%b bcd=000", seg_out, bcd_out, exp_seg);
    end
    send(10'd50, lat);
    exp_seg = LZ ? {SB, S5, S0} : {S0, S5, S0};
    n_checks++;
    if (seg_out !== exp_seg || bcd_out !== 12'h050) begin
      n_fail++; $display("FAIL blank_50 seg=%b bcd=%h exp seg=%b bcd=050", seg_out, bcd_out, exp_seg);
    end
  endtask

  task automatic test_wide();
    int lat;
    send2(14'd9999, lat);
    n_checks++;
    if (bcd_out2 !== 16'h9999 || overflow2 !== 1'b0 || lat !== 15) begin
      n_fail++; $display("FAIL wide_9999 bcd=%h ovf=%b lat=%0d exp 9999,0,15", bcd_out2, overflow2, lat);
    end
    send2(14'd16383, lat);
    n_checks++;
    if (bcd_out2 !== 16'h9999 || overflow2 !== 1'b1 || lat !== 15) begin
      n_fail++; $display("FAIL wide_16383 bcd=%h ovf=%b lat=%0d exp 9999,1,15", bcd_out2, overflow2, lat);
    end
    send2(14'd1234, lat);
    n_checks++;
    if (bcd_out2 !== 16'h1234 || overflow2 !== 1'b0) begin
      n_fail++; $display("FAIL wide_1234 bcd=%h ovf=%b exp 1234,0", bcd_out2, overflow2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    test_resubmit();
    test_blanking();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
